// File: rtl/ifetch_pkg.sv
// Shared types and bank-addressing helper for the banked instruction fetch memory.
// A fetch group may straddle a row boundary, so each bank computes its own row.
package ifetch_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic valid;
    logic misaligned;
    logic out_of_range;
  } fetch_status_t;

  typedef struct packed {
    logic [31:0] row;
    logic        past_end;
  } fetch_loc_t;

  // Banks below the start offset hold words that wrapped into the next row.
  function automatic fetch_loc_t fetch_bank_row(
    input logic [31:0] start_word,
    input logic [31:0] bank,
    input int unsigned logfw,
    input logic [31:0] rows
  );
    fetch_loc_t  loc;
    logic [31:0] mask;
    logic [31:0] offset;
    mask         = (32'd1 << logfw) - 32'd1;
    offset       = start_word & mask;
    loc.row      = (start_word >> logfw) + ((bank < offset) ? 32'd1 : 32'd0);
    loc.past_end = (loc.row >= rows);
    return loc;
  endfunction

endpackage

// File: rtl/instr_mem_bank.sv
// One storage bank: byte-enabled synchronous write, registered read-first read.
// Dropping rd_en freezes the read register so a stalled group stays on the bus.
module instr_mem_bank
  import ifetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ROWS  = 1024,
  parameter int unsigned ROW_W = 10
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ROW_W-1:0]   wr_row,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               rd_en,
  input  logic [ROW_W-1:0]   rd_row,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem_q [ROWS];
  logic [WIDTH-1:0] rd_data_q;

  // Read and write share one process so a same-row access sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < WIDTH / 8; k++) begin
        if (wr_be[k]) begin
          mem_q[wr_row][k*8 +: 8] <= wr_data[k*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_row];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Banked IF-stage instruction memory returning FETCH_W consecutive words per access.
// Bank read registers plus a small status register give one-cycle fetch latency.
module instr_fetch_mem #(
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  SIZE     = 1024,
  parameter int unsigned  FETCH_W  = 1,
  parameter logic [31:0]  NOP_WORD = ifetch_pkg::NOP_WORD,
  localparam int unsigned LOGSIZE  = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [LOGSIZE+1:0]       wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic                     req_valid,
  input  logic [31:0]              pc,
  input  logic                     stall,
  input  logic                     flush,
  output logic [FETCH_W*WIDTH-1:0] instr_out,
  output logic                     instr_valid,
  output logic [31:0]              instr_pc,
  output logic                     misaligned,
  output logic                     out_of_range
);

  import ifetch_pkg::*;

  localparam int unsigned LOGFW    = $clog2(FETCH_W);
  localparam int unsigned ROWS     = SIZE / FETCH_W;
  localparam int unsigned ROW_W    = (LOGSIZE > LOGFW) ? LOGSIZE - LOGFW : 1;
  localparam int unsigned OFF_W    = (LOGFW > 0) ? LOGFW : 1;
  localparam logic [32:0] END_BYTE = 33'(SIZE) << 2;

  fetch_status_t    status_q, status_d;
  logic [31:0]      pc_q, pc_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [FETCH_W-1:0] pe_q, pe_d, pe_req;

  logic [WIDTH-1:0] bank_data [FETCH_W];
  logic [ROW_W-1:0] rd_row [FETCH_W];
  logic [31:0]      start_word;
  logic             req_misaligned;
  logic             req_oor;
  logic             rd_en;
  logic             live;
  logic [OFF_W-1:0] sel;

  logic [LOGSIZE-1:0] wr_word;
  logic [LOGSIZE-1:0] wr_row_full;
  logic [ROW_W-1:0]   wr_row;
  logic               unused_wr;

  assign start_word     = {2'b00, pc[31:2]};
  assign req_misaligned = (pc[1:0] != 2'b00);
  assign req_oor        = ({1'b0, pc} >= END_BYTE);
  assign rd_en          = !stall;

  assign wr_word     = wr_addr[LOGSIZE+1:2];
  assign wr_row_full = wr_word >> LOGFW;
  assign wr_row      = wr_row_full[ROW_W-1:0];
  assign unused_wr   = ^{wr_addr[1:0], wr_row_full};

  for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_bank
    fetch_loc_t loc;
    logic       bank_we;
    logic       unused_row;

    assign loc        = fetch_bank_row(start_word, 32'(gi), LOGFW, 32'(ROWS));
    assign rd_row[gi] = loc.row[ROW_W-1:0];
    assign pe_req[gi] = loc.past_end;
    assign unused_row = ^loc.row;

    if (FETCH_W == 1) begin : g_one
      assign bank_we = wr_en;
    end else begin : g_many
      assign bank_we = wr_en && (wr_word[OFF_W-1:0] == OFF_W'(gi));
    end

    instr_mem_bank #(
      .WIDTH (WIDTH),
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .wr_be   (wr_be),
      .rd_en   (rd_en),
      .rd_row  (rd_row[gi]),
      .rd_data (bank_data[gi])
    );
  end

  // Priority: flush, then stall (hold everything), then request, then idle.
  always_comb begin
    status_d = status_q;
    pc_d     = pc_q;
    off_d    = off_q;
    pe_d     = pe_q;
    if (flush) begin
      status_d = '0;
      pc_d     = pc;
    end else if (!stall) begin
      if (req_valid) begin
        status_d.valid        = 1'b1;
        status_d.misaligned   = req_misaligned;
        status_d.out_of_range = req_oor;
        pc_d                  = pc;
        off_d                 = (FETCH_W > 1) ? start_word[OFF_W-1:0] : '0;
        pe_d                  = pe_req;
      end else begin
        status_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= '0;
      pc_q     <= '0;
      off_q    <= '0;
      pe_q     <= '0;
    end else begin
      status_q <= status_d;
      pc_q     <= pc_d;
      off_q    <= off_d;
      pe_q     <= pe_d;
    end
  end

  assign live = status_q.valid && !status_q.misaligned && !status_q.out_of_range;

  // Slot i holds word start+i, which lives in bank (offset+i) mod FETCH_W.
  always_comb begin
    instr_out = {FETCH_W{NOP_WORD}};
    sel       = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      sel = off_q + OFF_W'(i);
      if (live && !pe_q[sel]) begin
        instr_out[i*WIDTH +: WIDTH] = bank_data[sel];
      end
    end
  end

  assign instr_valid  = status_q.valid;
  assign instr_pc     = pc_q;
  assign misaligned   = status_q.misaligned;
  assign out_of_range = status_q.out_of_range;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench: a FETCH_W=4 and a FETCH_W=1 memory share one stimulus stream;
// a word-array reference model predicts each cycle's outputs for both.
module tb_instr_fetch_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         reset_n;
  logic         wr_en;
  logic [11:0]  wr_addr;
  logic [31:0]  wr_data;
  logic [3:0]   wr_be;
  logic         req_valid;
  logic [31:0]  pc;
  logic         stall;
  logic         flush;

  logic [127:0] o4;
  logic         v4, mis4, oor4;
  logic [31:0]  pc4;
  logic [31:0]  o1;
  logic         v1, mis1, oor1;
  logic [31:0]  pc1;

  instr_fetch_mem #(.SIZE(1024), .FETCH_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .req_valid(req_valid), .pc(pc), .stall(stall), .flush(flush),
    .instr_out(o4), .instr_valid(v4), .instr_pc(pc4), .misaligned(mis4), .out_of_range(oor4)
  );

  instr_fetch_mem #(.SIZE(1024), .FETCH_W(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .req_valid(req_valid), .pc(pc), .stall(stall), .flush(flush),
    .instr_out(o1), .instr_valid(v1), .instr_pc(pc1), .misaligned(mis1), .out_of_range(oor1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] out;
    logic         valid;
    logic [31:0]  pc;
    logic         mis;
    logic         oor;
  } exp_t;

  logic [31:0] mem_m [1024];
  exp_t        cur;
  exp_t        exp_q [$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] ex);
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, ex);
    end
  endtask

  function automatic exp_t reset_state();
    exp_t r;
    r.out   = {4{NOP}};
    r.valid = 1'b0;
    r.pc    = 32'h0;
    r.mis   = 1'b0;
    r.oor   = 1'b0;
    return r;
  endfunction

  task automatic model_write(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                             input logic [3:0] be);
    int w;
    if (we) begin
      w = int'(wa[11:2]);
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_m[w][k*8 +: 8] = wd[k*8 +: 8];
      end
    end
  endtask

  // One cycle of stimulus; the predicted post-edge outputs go to the scoreboard.
  task automatic drive(input logic rq, input logic [31:0] p, input logic st, input logic fl,
                       input logic we, input logic [11:0] wa, input logic [31:0] wd,
                       input logic [3:0] be);
    exp_t nxt;
    int   w;
    @(negedge clk);
    req_valid = rq; pc = p; stall = st; flush = fl;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    nxt = cur;
    if (fl) begin
      nxt.out = {4{NOP}}; nxt.valid = 1'b0; nxt.mis = 1'b0; nxt.oor = 1'b0; nxt.pc = p;
    end else if (st) begin
      nxt = cur;
    end else if (rq) begin
      nxt.valid = 1'b1;
      nxt.pc    = p;
      nxt.mis   = (p % 4) != 0;
      nxt.oor   = p >= 32'd4096;
      for (int s = 0; s < 4; s++) begin
        w = int'(p / 4) + s;
        if (nxt.mis || nxt.oor || w >= 1024) nxt.out[s*32 +: 32] = NOP;
        else nxt.out[s*32 +: 32] = mem_m[w];
      end
    end else begin
      nxt.out = {4{NOP}}; nxt.valid = 1'b0; nxt.mis = 1'b0; nxt.oor = 1'b0;
    end
    model_write(we, wa, wd, be);
    cur = nxt;
    exp_q.push_back(nxt);
  endtask

  task automatic fetch(input logic [31:0] p);
    drive(1'b1, p, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
  endtask

  task automatic write_word(input int w, input logic [31:0] d, input logic [3:0] be);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 12'(w * 4), d, be);
  endtask

  // Reset asserted between edges must clear outputs immediately; a loader write
  // issued during reset must still land.
  task automatic do_reset(input int w, input logic [31:0] d);
    @(negedge clk);
    reset_n = 1'b0;
    req_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wr_en = 1'b1; wr_addr = 12'(w * 4); wr_data = d; wr_be = 4'hF;
    #1;
    chk("rst_out4", o4, {4{NOP}});
    chk("rst_valid4", {127'b0, v4}, 128'b0);
    chk("rst_pc4", {96'b0, pc4}, 128'b0);
    chk("rst_flags4", {126'b0, mis4, oor4}, 128'b0);
    chk("rst_out1", {96'b0, o1}, {96'b0, NOP});
    chk("rst_valid1", {127'b0, v1}, 128'b0);
    chk("rst_flags1", {126'b0, mis1, oor1}, 128'b0);
    cur = reset_state();
    model_write(1'b1, 12'(w * 4), d, 4'hF);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out4", o4, e.out);
        chk("valid4", {127'b0, v4}, {127'b0, e.valid});
        chk("pc4", {96'b0, pc4}, {96'b0, e.pc});
        chk("flags4", {126'b0, mis4, oor4}, {126'b0, e.mis, e.oor});
        chk("out1", {96'b0, o1}, {96'b0, e.out[31:0]});
        chk("valid1", {127'b0, v1}, {127'b0, e.valid});
        chk("pc1", {96'b0, pc1}, {96'b0, e.pc});
        chk("flags1", {126'b0, mis1, oor1}, {126'b0, e.mis, e.oor});
      end
    end
  end

  initial begin : stimulus
    logic [31:0] p;
    logic [3:0]  be;
    int          sel;
    reset_n = 1'b0; req_valid = 1'b0; pc = 32'h0; stall = 1'b0; flush = 1'b0;
    wr_en = 1'b0; wr_addr = 12'h0; wr_data = 32'h0; wr_be = 4'h0;
    cur = reset_state();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int w = 0; w < 1024; w++) write_word(w, $urandom, 4'hF);
    write_word(5, 32'hDEAD_BEEF, 4'hF);
    for (int w = 6; w <= 9; w++) write_word(w, 32'hA0 + 32'(w), 4'hF);
    write_word(2, 32'h77, 4'hF);
    write_word(3, 32'h1122_3344, 4'hF);

    fetch(32'h14);
    do_reset(100, 32'hCAFE_0100);
    fetch(32'h14);
    fetch(32'h190);
    fetch(32'h18);

    fetch(32'h14);
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 12'h0, 32'h0, 4'h0);
    fetch(32'h14);
    drive(1'b0, 32'h44, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    fetch(32'h16);
    fetch(32'h1000);
    fetch(32'h1002);
    fetch(32'hFF8);
    fetch(32'hFFC);

    write_word(3, 32'hAABB_CCDD, 4'b0101);
    fetch(32'h0C);

    drive(1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 12'h008, 32'h55, 4'hF);
    fetch(32'h08);

    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4, 5: p = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        6:                p = {20'h0, 12'($urandom_range(0, 4095))} | 32'h1;
        7:                p = {20'h0, 10'($urandom_range(1019, 1023)), 2'b00};
        8:                p = 32'h1000 + {$urandom_range(0, 255), 2'b00};
        default:          p = $urandom;
      endcase
      be = 4'($urandom);
      drive($urandom_range(0, 9) < 7, p, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 3, 12'($urandom), $urandom, be);
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
